// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, and an optional
// first-word-fall-through read port. Pointers carry an extra wrap bit to separate full from empty.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] LVL_AF = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] LVL_AE = (AW+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr, r_rd_ptr;
  logic                  r_ovf, r_unf;

  logic                  w_full, w_empty, w_rd_acc, w_wr_acc;
  logic [AW:0]           w_count;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  // Modular pointer difference yields 0..DEPTH thanks to the wrap bit.
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_rd_acc = rd_en_i && !w_empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO is still taken.
  assign w_wr_acc = wr_en_i && (!w_full || w_rd_acc);
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ovf <= wr_en_i && !w_wr_acc;
      r_unf <= rd_en_i && !w_rd_acc;
    end
  end

  // Storage is never cleared; reset only blocks the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_wr_acc) r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data_o = w_empty ? '0 : w_head;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_rd_data;
      always_ff @(posedge clk_i) begin
        if (rst_i)         r_rd_data <= '0;
        else if (w_rd_acc) r_rd_data <= w_head;
      end
      assign rd_data_o = r_rd_data;
    end
  endgenerate

  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign count_o        = w_count;
  assign almost_full_o  = (w_count >= LVL_AF);
  assign almost_empty_o = (w_count <= LVL_AE);
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_unf;

endmodule
